qu_rob: RTL and testbench
=========================

# qu_rob

Reorder buffer for the Qu out-of-order core. It allocates one entry per dispatched instruction in program order and records result writebacks arriving out of order. It retires completed entries in order from the head and exposes two operand-lookup ports that the reservation station uses to resolve `qj`/`qk` tags. It sits between dispatch/rename (upstream) and the physical register file commit path (downstream), alongside the reservation station.

## Interface
- `DEPTH`, default `ROB_DEPTH` (8): number of entries; must be a power of two.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous squash of all entries
- `alloc_valid`  in  1  dispatch requests an entry
- `alloc_ready`  out  1  entry available (`!full && !flush`)
- `alloc_dest`  in  `PHY_RF_ADDR_WIDTH`  physical destination register
- `alloc_rob_addr`  out  `ROB_ADDR_WIDTH`  tag assigned on this cycle (current tail)
- `issue_valid`  in  1  reservation station issued the entry to a unit
- `issue_rob_addr`  in  `ROB_ADDR_WIDTH`  issued tag
- `wb_valid`  in  1  result writeback
- `wb_rob_addr`  in  `ROB_ADDR_WIDTH`  writeback tag
- `wb_value`  in  32  result value
- `commit_valid`  out  1  head entry is complete
- `commit_ready`  in  1  downstream accepts the commit
- `commit_rob_addr`  out  `ROB_ADDR_WIDTH`  head tag
- `commit_dest`  out  `PHY_RF_ADDR_WIDTH`  head destination
- `commit_value`  out  32  head value
- `lookup_j_addr`, `lookup_k_addr`  in  `ROB_ADDR_WIDTH`  operand tags
- `lookup_j_ready`, `lookup_k_ready`  out  1  tagged entry state is RETIRED
- `lookup_j_value`, `lookup_k_value`  out  32  tagged entry value
- `full`, `empty`  out  1  occupancy flags
- `count`  out  `ROB_ADDR_WIDTH+1`  occupied entries, 0..DEPTH

## Operation
- Each entry is a `rob_cell_t` holding value, dest and state.
- State encoding: EMPTY=00, RETIRED=01 (result written), EXECUTE=10, PENDING=11.
- Entry lifecycle:
  - Alloc: on `alloc_valid && alloc_ready`, the entry at tail becomes PENDING, dest=`alloc_dest`, value=0, and tail increments.
  - Issue: on `issue_valid`, a PENDING entry becomes EXECUTE. Issue to any other state is ignored.
  - Writeback: on `wb_valid`, a PENDING or EXECUTE entry becomes RETIRED with value=`wb_value`. Writeback to EMPTY or RETIRED is ignored.
  - Commit: `commit_valid = !empty && state[head]==RETIRED`. On `commit_valid && commit_ready`, the entry becomes EMPTY and head increments.
- Same cycle, same tag, issue and writeback: writeback wins (RETIRED).
- Alloc and commit in the same cycle are both honoured; count is unchanged. Alloc is allowed when full only if… no: `alloc_ready` depends on registered `full` only, so there is no same-cycle bypass from commit.
- `head`, `tail` wrap modulo DEPTH. `count` disambiguates `head==tail`; `full = count==DEPTH`, `empty = count==0`.
- Lookup ports and commit outputs are purely combinational reads of registered state. There is no writeback bypass.
- Flush has top priority. All entries go EMPTY, head=tail=count=0, and alloc/issue/wb/commit in that cycle are discarded.

## Timing
- Reset (async assert, sync deassert assumed by the SoC): all entries EMPTY with value=0 and dest=0; head=tail=count=0.
  - Outputs at reset: `empty`=1, `full`=0, `alloc_ready`=1, `commit_valid`=0, lookups ready=0 / value=0, `alloc_rob_addr`=0.
- Minimum lifetime: alloc in cycle N, wb in N+1, `commit_valid` in N+2.
- A writeback in cycle N makes `lookup_*_ready` high from N+1.
- Reset mid-operation discards all in-flight entries immediately; no commit is emitted.

## Structure
- Uses `qu_common`: `rob_cell_t`, `rob_addr_t`, `ROB_STATE_*`, `ROB_DEPTH`, `PHY_RF_ADDR_WIDTH`.
- Add `ROB_COUNT_WIDTH = ROB_ADDR_WIDTH+1` to `qu_common`.
- Single module; no sub-module warranted. The two lookup ports are identical mux instances and may be generated from one function.

## Test plan
- Reset, then alloc dest=5 → `alloc_rob_addr`=0, next cycle `count`=1; wb tag 0 value 0xDEADBEEF → next cycle `commit_valid`=1, `commit_dest`=5, `commit_value`=0xDEADBEEF; accept → `empty`=1.
- Fill 8 entries → `full`=1, `alloc_ready`=0; wb tags 3,1,0 out of order → commits tag 0 then 1 only, tag 2 blocks the head, tag 3 stays RETIRED.
- Wrap-around: 20 alloc/commit pairs with simultaneous alloc+commit → tags cycle 0..7, `count` stays constant, values match in order.
- Issue and wb to the same tag in one cycle → state RETIRED; a later wb to a RETIRED tag leaves the value unchanged; issue to an EMPTY tag → no change.
- `lookup_j_addr`=2 before and after wb 0x1234 to tag 2 → ready 0 then ready 1 with value 0x1234 one cycle after wb.
- Flush with 5 entries and a concurrent alloc → next cycle `count`=0, `empty`=1, all lookups ready=0; assert `rst_n`=0 mid-stream → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/qu_common.sv
// ============================================================================
// Module      : qu_common
// Description : Shared types and constants for the Qu out-of-order core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qu_common;

  localparam int ROB_DEPTH         = 8;
  localparam int ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH);
  localparam int ROB_COUNT_WIDTH   = ROB_ADDR_WIDTH + 1;
  localparam int PHY_RF_ADDR_WIDTH = 6;

  // Entry lifecycle encoding; RETIRED means "result written, awaiting commit"
  localparam logic [1:0] ROB_STATE_EMPTY   = 2'b00;
  localparam logic [1:0] ROB_STATE_RETIRED = 2'b01;
  localparam logic [1:0] ROB_STATE_EXECUTE = 2'b10;
  localparam logic [1:0] ROB_STATE_PENDING = 2'b11;

  typedef logic [ROB_ADDR_WIDTH-1:0]    rob_addr_t;
  typedef logic [ROB_COUNT_WIDTH-1:0]   rob_count_t;
  typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_addr_t;

  typedef struct packed {
    logic [31:0] value;
    phy_addr_t   dest;
    logic [1:0]  state;
  } rob_cell_t;

endpackage

`default_nettype wire

// File: rtl/qu_rob_if.sv
// ============================================================================
// Module      : qu_rob_if
// Description : Dispatch, issue, writeback, commit and lookup bundle of qu_rob.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qu_rob_if;
  import qu_common::*;

  logic        alloc_valid;
  logic        alloc_ready;
  phy_addr_t   alloc_dest;
  rob_addr_t   alloc_rob_addr;
  logic        issue_valid;
  rob_addr_t   issue_rob_addr;
  logic        wb_valid;
  rob_addr_t   wb_rob_addr;
  logic [31:0] wb_value;
  logic        commit_valid;
  logic        commit_ready;
  rob_addr_t   commit_rob_addr;
  phy_addr_t   commit_dest;
  logic [31:0] commit_value;
  rob_addr_t   lookup_j_addr;
  rob_addr_t   lookup_k_addr;
  logic        lookup_j_ready;
  logic        lookup_k_ready;
  logic [31:0] lookup_j_value;
  logic [31:0] lookup_k_value;
  logic        full;
  logic        empty;
  rob_count_t  count;

  modport slave (
    input  alloc_valid, alloc_dest, issue_valid, issue_rob_addr,
           wb_valid, wb_rob_addr, wb_value, commit_ready,
           lookup_j_addr, lookup_k_addr,
    output alloc_ready, alloc_rob_addr, commit_valid, commit_rob_addr,
           commit_dest, commit_value, lookup_j_ready, lookup_k_ready,
           lookup_j_value, lookup_k_value, full, empty, count
  );

  modport master (
    output alloc_valid, alloc_dest, issue_valid, issue_rob_addr,
           wb_valid, wb_rob_addr, wb_value, commit_ready,
           lookup_j_addr, lookup_k_addr,
    input  alloc_ready, alloc_rob_addr, commit_valid, commit_rob_addr,
           commit_dest, commit_value, lookup_j_ready, lookup_k_ready,
           lookup_j_value, lookup_k_value, full, empty, count
  );

endinterface

`default_nettype wire

// File: rtl/qu_rob.sv
// ============================================================================
// Module      : qu_rob
// Description : In-order allocate / out-of-order writeback / in-order commit
//               reorder buffer with two operand-lookup ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qu_rob
  import qu_common::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  qu_rob_if.slave   rob
);

  rob_cell_t  r_cells [DEPTH];
  rob_addr_t  r_head;
  rob_addr_t  r_tail;
  rob_count_t r_count;

  logic       w_full;
  logic       w_empty;
  logic       w_alloc;
  logic       w_commit;
  logic       w_commit_valid;
  rob_cell_t  w_head_cell;

  function automatic rob_cell_t read_cell(input rob_addr_t addr);
    return r_cells[addr];
  endfunction

  assign w_full         = (r_count == rob_count_t'(DEPTH));
  assign w_empty        = (r_count == '0);
  assign w_head_cell    = read_cell(r_head);
  assign w_commit_valid = !w_empty && (w_head_cell.state == ROB_STATE_RETIRED);
  assign w_alloc        = rob.alloc_valid && rob.alloc_ready;
  assign w_commit       = w_commit_valid && rob.commit_ready;

  // alloc_ready looks only at registered occupancy; a same-cycle commit does not free a slot
  assign rob.alloc_ready     = !w_full && !flush;
  assign rob.alloc_rob_addr  = r_tail;
  assign rob.commit_valid    = w_commit_valid;
  assign rob.commit_rob_addr = r_head;
  assign rob.commit_dest     = w_head_cell.dest;
  assign rob.commit_value    = w_head_cell.value;
  assign rob.full            = w_full;
  assign rob.empty           = w_empty;
  assign rob.count           = r_count;

  assign rob.lookup_j_ready  = (read_cell(rob.lookup_j_addr).state == ROB_STATE_RETIRED);
  assign rob.lookup_j_value  = read_cell(rob.lookup_j_addr).value;
  assign rob.lookup_k_ready  = (read_cell(rob.lookup_k_addr).state == ROB_STATE_RETIRED);
  assign rob.lookup_k_value  = read_cell(rob.lookup_k_addr).value;

  // head/tail wrap naturally because DEPTH equals 2**ROB_ADDR_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cells[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cells[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // writeback takes precedence over a same-tag issue
        if (rob.wb_valid && (rob.wb_rob_addr == rob_addr_t'(i)) &&
            ((r_cells[i].state == ROB_STATE_PENDING) ||
             (r_cells[i].state == ROB_STATE_EXECUTE))) begin
          r_cells[i].state <= ROB_STATE_RETIRED;
          r_cells[i].value <= rob.wb_value;
        end else if (rob.issue_valid && (rob.issue_rob_addr == rob_addr_t'(i)) &&
                     (r_cells[i].state == ROB_STATE_PENDING)) begin
          r_cells[i].state <= ROB_STATE_EXECUTE;
        end
        if (w_alloc && (r_tail == rob_addr_t'(i))) begin
          r_cells[i].value <= '0;
          r_cells[i].dest  <= rob.alloc_dest;
          r_cells[i].state <= ROB_STATE_PENDING;
        end
        if (w_commit && (r_head == rob_addr_t'(i))) begin
          r_cells[i].state <= ROB_STATE_EMPTY;
        end
      end
      if (w_alloc) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_commit) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qu_rob.sv
// ============================================================================
// Module      : tb_qu_rob
// Description : Directed vector table plus hand-written sequences for qu_rob.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qu_rob;
  import qu_common::*;

  typedef struct {
    logic        a_v;
    logic [5:0]  a_dest;
    logic        i_v;
    logic [2:0]  i_addr;
    logic        w_v;
    logic [2:0]  w_addr;
    logic [31:0] w_val;
    logic        c_rdy;
    logic [2:0]  lj;
    logic [2:0]  lk;
    logic [3:0]  e_count;
    logic [2:0]  e_aaddr;
    logic        e_cv;
    logic [2:0]  e_caddr;
    logic [5:0]  e_cdest;
    logic [31:0] e_cval;
    logic        e_jr;
    logic [31:0] e_jv;
    logic        e_kr;
    logic [31:0] e_kv;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  vec_t vecs [12];

  qu_rob_if rif ();

  qu_rob #(.DEPTH(ROB_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .rob   (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rif.alloc_valid    = 1'b0;
    rif.alloc_dest     = '0;
    rif.issue_valid    = 1'b0;
    rif.issue_rob_addr = '0;
    rif.wb_valid       = 1'b0;
    rif.wb_rob_addr    = '0;
    rif.wb_value       = '0;
    rif.commit_ready   = 1'b0;
    rif.lookup_j_addr  = '0;
    rif.lookup_k_addr  = '0;
    flush              = 1'b0;
  endtask

  // inputs change on the falling edge; checks run 1 time unit later
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".empty"},          32'(rif.empty), 32'd1);
    chk({tag, ".full"},           32'(rif.full), 32'd0);
    chk({tag, ".count"},          32'(rif.count), 32'd0);
    chk({tag, ".alloc_ready"},    32'(rif.alloc_ready), 32'd1);
    chk({tag, ".alloc_rob_addr"}, 32'(rif.alloc_rob_addr), 32'd0);
    chk({tag, ".commit_valid"},   32'(rif.commit_valid), 32'd0);
    chk({tag, ".lookup_j_ready"}, 32'(rif.lookup_j_ready), 32'd0);
    chk({tag, ".lookup_j_value"}, rif.lookup_j_value, 32'd0);
    chk({tag, ".lookup_k_ready"}, 32'(rif.lookup_k_ready), 32'd0);
    chk({tag, ".lookup_k_value"}, rif.lookup_k_value, 32'd0);
  endtask

  initial begin
    //          a_v dst i_v ia w_v wa val            rdy lj lk | cnt aa cv ca cd cval           jr jv            kr kv
    vecs[0]  = '{1, 5, 0, 0, 0, 0, 32'h0,          0, 0, 1,  0, 0, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0};
    vecs[1]  = '{0, 0, 0, 0, 1, 0, 32'hDEADBEEF,   0, 0, 1,  1, 1, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 32'h0,          1, 0, 2,  1, 1, 1, 0, 5, 32'hDEADBEEF,   1, 32'hDEADBEEF, 0, 32'h0};
    vecs[3]  = '{1, 7, 0, 0, 0, 0, 32'h0,          0, 2, 3,  0, 1, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0};
    vecs[4]  = '{1, 8, 0, 0, 0, 0, 32'h0,          0, 2, 1,  1, 2, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0};
    vecs[5]  = '{0, 0, 0, 0, 1, 2, 32'h1234,       0, 2, 1,  2, 3, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0};
    vecs[6]  = '{0, 0, 1, 1, 1, 1, 32'h55,         0, 2, 1,  2, 3, 0, 0, 0, 32'h0,          1, 32'h1234,     0, 32'h0};
    vecs[7]  = '{0, 0, 0, 0, 1, 1, 32'h99,         0, 1, 2,  2, 3, 1, 1, 7, 32'h55,         1, 32'h55,       1, 32'h1234};
    vecs[8]  = '{0, 0, 1, 5, 0, 0, 32'h0,          0, 1, 5,  2, 3, 1, 1, 7, 32'h55,         1, 32'h55,       0, 32'h0};
    vecs[9]  = '{0, 0, 0, 0, 1, 5, 32'hAB,         1, 1, 5,  2, 3, 1, 1, 7, 32'h55,         1, 32'h55,       0, 32'h0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 32'h0,          1, 5, 2,  1, 3, 1, 2, 8, 32'h1234,       0, 32'h0,        1, 32'h1234};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 32'h0,          0, 5, 4,  0, 3, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0};

    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      rif.alloc_valid    = vecs[i].a_v;
      rif.alloc_dest     = vecs[i].a_dest;
      rif.issue_valid    = vecs[i].i_v;
      rif.issue_rob_addr = vecs[i].i_addr;
      rif.wb_valid       = vecs[i].w_v;
      rif.wb_rob_addr    = vecs[i].w_addr;
      rif.wb_value       = vecs[i].w_val;
      rif.commit_ready   = vecs[i].c_rdy;
      rif.lookup_j_addr  = vecs[i].lj;
      rif.lookup_k_addr  = vecs[i].lk;
      #1;
      chk($sformatf("v%0d.count", i),          32'(rif.count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d.empty", i),          32'(rif.empty), 32'(vecs[i].e_count == 4'd0));
      chk($sformatf("v%0d.alloc_rob_addr", i), 32'(rif.alloc_rob_addr), 32'(vecs[i].e_aaddr));
      chk($sformatf("v%0d.commit_valid", i),   32'(rif.commit_valid), 32'(vecs[i].e_cv));
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d.commit_rob_addr", i), 32'(rif.commit_rob_addr), 32'(vecs[i].e_caddr));
        chk($sformatf("v%0d.commit_dest", i),     32'(rif.commit_dest), 32'(vecs[i].e_cdest));
        chk($sformatf("v%0d.commit_value", i),    rif.commit_value, vecs[i].e_cval);
      end
      chk($sformatf("v%0d.lookup_j_ready", i), 32'(rif.lookup_j_ready), 32'(vecs[i].e_jr));
      chk($sformatf("v%0d.lookup_j_value", i), rif.lookup_j_value, vecs[i].e_jv);
      chk($sformatf("v%0d.lookup_k_ready", i), 32'(rif.lookup_k_ready), 32'(vecs[i].e_kr));
      chk($sformatf("v%0d.lookup_k_value", i), rif.lookup_k_value, vecs[i].e_kv);
      step();
    end

    // Fill to capacity, then out-of-order writebacks 3,1,0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_dest  = 6'(10 + i);
      #1;
      chk($sformatf("fill%0d.alloc_rob_addr", i), 32'(rif.alloc_rob_addr), 32'(i));
      chk($sformatf("fill%0d.alloc_ready", i),    32'(rif.alloc_ready), 32'd1);
      step();
    end
    rif.alloc_dest = 6'd63;
    #1;
    chk("full.full",        32'(rif.full), 32'd1);
    chk("full.alloc_ready", 32'(rif.alloc_ready), 32'd0);
    chk("full.count",       32'(rif.count), 32'd8);
    step();
    rif.alloc_valid = 1'b0;
    #1;
    chk("full.count_after_reject", 32'(rif.count), 32'd8);
    rif.wb_valid = 1'b1;
    rif.wb_rob_addr = 3'd3; rif.wb_value = 32'h1003; step();
    rif.wb_rob_addr = 3'd1; rif.wb_value = 32'h1001; step();
    rif.wb_rob_addr = 3'd0; rif.wb_value = 32'h1000; step();
    rif.wb_valid = 1'b0;
    rif.commit_ready = 1'b1;
    #1;
    chk("ooo.c0.valid", 32'(rif.commit_valid), 32'd1);
    chk("ooo.c0.addr",  32'(rif.commit_rob_addr), 32'd0);
    chk("ooo.c0.dest",  32'(rif.commit_dest), 32'd10);
    chk("ooo.c0.value", rif.commit_value, 32'h1000);
    step();
    #1;
    chk("ooo.c1.valid", 32'(rif.commit_valid), 32'd1);
    chk("ooo.c1.addr",  32'(rif.commit_rob_addr), 32'd1);
    chk("ooo.c1.dest",  32'(rif.commit_dest), 32'd11);
    chk("ooo.c1.value", rif.commit_value, 32'h1001);
    step();
    rif.lookup_j_addr = 3'd3;
    rif.lookup_k_addr = 3'd2;
    #1;
    chk("ooo.block.valid", 32'(rif.commit_valid), 32'd0);
    chk("ooo.block.count", 32'(rif.count), 32'd6);
    chk("ooo.tag3.ready",  32'(rif.lookup_j_ready), 32'd1);
    chk("ooo.tag3.value",  rif.lookup_j_value, 32'h1003);
    chk("ooo.tag2.ready",  32'(rif.lookup_k_ready), 32'd0);
    step();
    #1;
    chk("ooo.hold.count", 32'(rif.count), 32'd6);
    rif.commit_ready = 1'b0;

    // Wrap-around: steady alloc + commit with count pinned at 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_dest  = 6'(i);
      step();
    end
    rif.alloc_valid = 1'b0;
    rif.wb_valid = 1'b1;
    rif.wb_rob_addr = 3'd0; rif.wb_value = 32'hA000; step();
    rif.wb_rob_addr = 3'd1; rif.wb_value = 32'hA001; step();
    for (int k = 0; k < 20; k++) begin
      rif.alloc_valid  = 1'b1;
      rif.alloc_dest   = 6'(3 + k);
      rif.wb_valid     = 1'b1;
      rif.wb_rob_addr  = 3'((2 + k) % 8);
      rif.wb_value     = 32'hA000 + 32'(2 + k);
      rif.commit_ready = 1'b1;
      #1;
      chk($sformatf("wrap%0d.commit_valid", k), 32'(rif.commit_valid), 32'd1);
      chk($sformatf("wrap%0d.commit_addr", k),  32'(rif.commit_rob_addr), 32'(k % 8));
      chk($sformatf("wrap%0d.commit_dest", k),  32'(rif.commit_dest), 32'(k));
      chk($sformatf("wrap%0d.commit_value", k), rif.commit_value, 32'hA000 + 32'(k));
      chk($sformatf("wrap%0d.alloc_addr", k),   32'(rif.alloc_rob_addr), 32'((3 + k) % 8));
      chk($sformatf("wrap%0d.count", k),        32'(rif.count), 32'd3);
      step();
    end
    idle_inputs();

    // Flush with five live entries and a concurrent alloc
    rif.alloc_valid = 1'b1;
    rif.alloc_dest  = 6'd1;
    step();
    step();
    rif.alloc_valid   = 1'b0;
    rif.lookup_j_addr = 3'd5;
    rif.lookup_k_addr = 3'd4;
    #1;
    chk("preflush.count",   32'(rif.count), 32'd5);
    chk("preflush.j_ready", 32'(rif.lookup_j_ready), 32'd1);
    chk("preflush.j_value", rif.lookup_j_value, 32'hA015);
    chk("preflush.k_ready", 32'(rif.lookup_k_ready), 32'd1);
    chk("preflush.k_value", rif.lookup_k_value, 32'hA014);
    flush = 1'b1;
    rif.alloc_valid = 1'b1;
    #1;
    chk("flush.alloc_ready", 32'(rif.alloc_ready), 32'd0);
    step();
    flush = 1'b0;
    rif.alloc_valid = 1'b0;
    #1;
    chk("postflush.count",        32'(rif.count), 32'd0);
    chk("postflush.empty",        32'(rif.empty), 32'd1);
    chk("postflush.commit_valid", 32'(rif.commit_valid), 32'd0);
    chk("postflush.alloc_addr",   32'(rif.alloc_rob_addr), 32'd0);
    for (int t = 0; t < 8; t++) begin
      rif.lookup_j_addr = 3'(t);
      rif.lookup_k_addr = 3'(7 - t);
      #1;
      chk($sformatf("postflush.j_ready%0d", t), 32'(rif.lookup_j_ready), 32'd0);
      chk($sformatf("postflush.k_ready%0d", t), 32'(rif.lookup_k_ready), 32'd0);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of traffic
    rif.alloc_valid = 1'b1;
    rif.alloc_dest  = 6'd9;
    step();
    rif.wb_valid    = 1'b1;
    rif.wb_rob_addr = 3'd0;
    rif.wb_value    = 32'h77;
    step();
    idle_inputs();
    #1;
    chk("midrst.pre.count",   32'(rif.count), 32'd2);
    chk("midrst.pre.cv",      32'(rif.commit_valid), 32'd1);
    chk("midrst.pre.j_ready", 32'(rif.lookup_j_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1;
    chk("afterrst.count", 32'(rif.count), 32'd0);
    chk("afterrst.cv",    32'(rif.commit_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
